uart_resp_tx: RTL and testbench

Response framer for the UART link. Accepts one readback request (8-bit address, 16-bit data) from the register side and serializes it as a 5-byte reply frame through the byte-level `tx_data`/`tx_wr`/`tx_done` handshake of `uart_transceiver`. It is the return-path counterpart of the command parser in `reg_fsm`, and sits between the register file and the transceiver's transmit side in `dig_core`.

---
 rtl/uart_resp_tx.sv | 86 ++++++++
 tb/tb_uart_resp_tx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: frames one register readback (hdr, addr, data hi, data lo, xor checksum)
// and feeds it byte by byte to the UART transmitter, aborting on a stuck tx_done.
module uart_resp_tx #(
   parameter logic [7:0] HDR_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [7:0]  addr_i,
   input  logic [15:0] data_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_wr_o,
   input  logic        tx_done_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
   state_t state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [CW-1:0] cnt;
   logic [7:0] addr_q, chk, byte_sel;
   logic [15:0] data_q;
   logic accept, done_nxt, err_nxt;
   assign accept = req_valid_i && req_ready_o;
   assign chk = addr_q ^ data_q[15:8] ^ data_q[7:0];
   assign tx_wr_o = state == SEND;
   assign busy_o = state != IDLE;
   // Byte 0 is selected on the accept edge, before addr/data are latched
   assign byte_sel = idx_nxt == 3'd0 ? HDR_BYTE :
                     idx_nxt == 3'd1 ? addr_q :
                     idx_nxt == 3'd2 ? data_q[15:8] :
                     idx_nxt == 3'd3 ? data_q[7:0] : chk;
   always_comb begin
      state_nxt = state;
      idx_nxt = idx;
      done_nxt = 1'b0;
      err_nxt = 1'b0;
      case (state)
         IDLE: if (accept) begin
            state_nxt = SEND;
            idx_nxt = 3'd0;
         end
         SEND: state_nxt = WAIT;
         WAIT: if (tx_done_i) begin
            state_nxt = idx == 3'd4 ? IDLE : SEND;
            idx_nxt = idx == 3'd4 ? idx : idx + 3'd1;
            done_nxt = idx == 3'd4;
         end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state_nxt = IDLE;
            err_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // Abort fires after TIMEOUT_CYC wait cycles; tx_done on the last of them still wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= 3'd0;
         cnt <= '0;
         addr_q <= 8'h00;
         data_q <= 16'h0000;
         req_ready_o <= 1'b0;
         tx_data_o <= 8'h00;
         done_o <= 1'b0;
         err_o <= 1'b0;
      end else begin
         state <= state_nxt;
         idx <= idx_nxt;
         req_ready_o <= state_nxt == IDLE;
         done_o <= done_nxt;
         err_o <= err_nxt;
         if (accept) begin
            addr_q <= addr_i;
            data_q <= data_i;
         end
         if (state_nxt == SEND) tx_data_o <= byte_sel;
         cnt <= state == SEND ? '0 :
                (state == WAIT && cnt != CW'(TIMEOUT_CYC)) ? cnt + 1'b1 : cnt;
      end
   end
endmodule

// File: tb/tb_uart_resp_tx.sv
// tb_uart_resp_tx: directed checks of framing, checksum, latching, timeout, tie,
// back-to-back requests, stray tx_done pulses and mid-frame reset.
module tb_uart_resp_tx;
   logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, tx_done = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [15:0] data = 16'h0000;
   logic req_ready, tx_wr, busy, done, err;
   logic [7:0] tx_data;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   uart_resp_tx #(.HDR_BYTE(8'hA5), .TIMEOUT_CYC(50)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .addr_i(addr), .data_i(data), .tx_data_o(tx_data), .tx_wr_o(tx_wr),
      .tx_done_i(tx_done), .busy_o(busy), .done_o(done), .err_o(err)
   );
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(negedge clk);
   endtask
   task automatic reset_vals(input string tag);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_wr"}, tx_wr, 0);
      chk({tag, "_data"}, tx_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask
   // Leaves the bench at the negedge of the header strobe cycle
   task automatic request(input logic [7:0] a, input logic [15:0] d, input bit hold);
      int n = 0;
      req_valid = 1'b1;
      addr = a;
      data = d;
      while (!req_ready && n < 100) begin
         tick;
         n++;
      end
      chk("accept_ready", req_ready, 1);
      tick;
      if (!hold) req_valid = 1'b0;
      chk("hdr_busy", busy, 1);
      chk("hdr_ready", req_ready, 0);
   endtask
   // At the strobe cycle S: check byte, answer tx_done sampled at S+d-1, return at S+d
   task automatic byte_step(input string tag, input logic [7:0] e, input int d, input bit stray);
      chk({tag, "_wr"}, tx_wr, 1);
      chk({tag, "_byte"}, tx_data, e);
      if (stray) tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk({tag, "_gap"}, tx_wr, 0);
      chk({tag, "_hold"}, tx_data, e);
      repeat (d - 2) tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
   endtask
   task automatic send_frame(input string tag, input logic [39:0] e, input int dly,
                             input int tie_idx, input int stray_idx);
      for (int i = 0; i < 5; i++)
         byte_step($sformatf("%s_b%0d", tag, i), e[39-8*i -: 8], i == tie_idx ? 51 : dly, i == stray_idx);
   endtask
   task automatic frame_end(input string tag);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_ready"}, req_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      tick;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_wr_idle"}, tx_wr, 0);
   endtask
   initial begin
      #2 reset_vals("rst");
      @(negedge clk) rst_n = 1'b1;
      #1 chk("ready_pre_edge", req_ready, 0);
      tick;
      chk("ready_after_rst", req_ready, 1);
      repeat (2) tick;
      request(8'h03, 16'h1234, 0);
      send_frame("basic", 40'hA5_03_12_34_25, 20, -1, -1);
      frame_end("basic");
      request(8'hFF, 16'hFF00, 0);
      addr = 8'h55;
      data = 16'h9999;
      send_frame("chk0", 40'hA5_FF_FF_00_00, 20, -1, -1);
      frame_end("chk0");
      request(8'h10, 16'h2030, 0);
      byte_step("to_b0", 8'hA5, 5, 0);
      chk("to_b1_wr", tx_wr, 1);
      chk("to_b1_byte", tx_data, 8'h10);
      repeat (50) tick;
      chk("to_pre_err", err, 0);
      chk("to_pre_busy", busy, 1);
      tick;
      chk("to_err", err, 1);
      chk("to_ready", req_ready, 1);
      chk("to_busy", busy, 0);
      chk("to_done", done, 0);
      tick;
      chk("to_err_pulse", err, 0);
      chk("to_wr", tx_wr, 0);
      request(8'h03, 16'h1234, 0);
      send_frame("post_to", 40'hA5_03_12_34_25, 6, -1, -1);
      frame_end("post_to");
      request(8'h03, 16'h1234, 0);
      send_frame("tie", 40'hA5_03_12_34_25, 8, 2, -1);
      frame_end("tie");
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("idle_stray_busy", busy, 0);
      chk("idle_stray_wr", tx_wr, 0);
      tick;
      chk("idle_stray_busy2", busy, 0);
      request(8'h03, 16'h1234, 1);
      addr = 8'h04;
      data = 16'hABCD;
      send_frame("b2b1", 40'hA5_03_12_34_25, 20, -1, -1);
      chk("b2b1_done", done, 1);
      chk("b2b1_ready", req_ready, 1);
      tick;
      req_valid = 1'b0;
      chk("b2b2_hdr_busy", busy, 1);
      send_frame("b2b2", 40'hA5_04_AB_CD_62, 10, -1, 0);
      frame_end("b2b2");
      request(8'h07, 16'hBEEF, 0);
      byte_step("mr_b0", 8'hA5, 10, 0);
      byte_step("mr_b1", 8'h07, 10, 0);
      byte_step("mr_b2", 8'hBE, 10, 0);
      chk("mr_b3_byte", tx_data, 8'hEF);
      repeat (3) tick;
      rst_n = 1'b0;
      #1 reset_vals("mid_rst");
      @(negedge clk) rst_n = 1'b1;
      #1 chk("mr_ready_pre_edge", req_ready, 0);
      tick;
      chk("mr_ready_after", req_ready, 1);
      request(8'h03, 16'h1234, 0);
      send_frame("post_rst", 40'hA5_03_12_34_25, 4, -1, -1);
      frame_end("post_rst");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
